// File: rtl/int_resize_stream.sv
// int_resize_stream: multi-lane streaming integer width/signedness converter.
// Each lane is read as an IN_W-bit signed or unsigned integer and re-expressed as an OUT_W-bit
// signed or unsigned integer. Out-of-range lanes raise out_ovf_o. The overflowing lane value
// wraps by default. Define INT_RESIZE_SAT_EN to clamp it to the nearest bound instead.
// The output is registered and backed by a one-entry skid buffer. This gives full throughput,
// and in_ready_o comes straight from a flop.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   in_valid_i    input beat valid
//   in_ready_o    input may be accepted (registered, = !skid full)
//   in_data_i     LANES packed input lanes, lane k = [k*IN_W +: IN_W]
//   out_valid_o   output beat valid
//   out_ready_i   downstream accepts
//   out_data_o    LANES packed converted lanes
//   out_ovf_o     per-lane "value not representable" flag, travels with out_data_o
//   ovf_count_o   saturating count of output transfers with any out_ovf_o bit set
module int_resize_stream #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned OUT_W      = 8,
  parameter bit          IN_SIGNED  = 1'b1,
  parameter bit          OUT_SIGNED = 1'b1,
  parameter int unsigned LANES      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*IN_W-1:0]  in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*OUT_W-1:0] out_data_o,
  output logic [LANES-1:0]       out_ovf_o,
  output logic [15:0]            ovf_count_o
);

  // Wide enough to hold any input value and both output bounds with a spare sign bit.
  localparam int unsigned VW       = ((IN_W > OUT_W) ? IN_W : OUT_W) + 2;
  localparam int unsigned MaxShift = OUT_SIGNED ? OUT_W - 1 : OUT_W;

  logic signed [VW-1:0] out_max, out_min;
  assign out_max = (VW'(1) << MaxShift) - VW'(1);
  assign out_min = OUT_SIGNED ? -(VW'(1) << (OUT_W - 1)) : '0;

  // Per-lane conversion of the incoming beat.
  logic [LANES*OUT_W-1:0] conv_data;
  logic [LANES-1:0]       conv_ovf;
  logic [IN_W-1:0]        lane;
  logic                   ext;
  logic signed [VW-1:0]   v;

  always_comb begin
    conv_data = '0;
    conv_ovf  = '0;
    lane      = '0;
    ext       = 1'b0;
    v         = '0;
    for (int k = 0; k < LANES; k++) begin
      lane        = in_data_i[k*IN_W +: IN_W];
      ext         = IN_SIGNED ? lane[IN_W-1] : 1'b0;
      v           = {{(VW-IN_W){ext}}, lane};
      conv_ovf[k] = (v > out_max) || (v < out_min);
`ifdef INT_RESIZE_SAT_EN
      if (v > out_max) begin
        conv_data[k*OUT_W +: OUT_W] = out_max[OUT_W-1:0];
      end else if (v < out_min) begin
        conv_data[k*OUT_W +: OUT_W] = out_min[OUT_W-1:0];
      end else begin
        conv_data[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
`else
      // v is already extended per input signedness, so truncation is plain SV wrap.
      conv_data[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
`endif
    end
  end

  // Output register, skid buffer and overflow counter.
  logic                   out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_ovf_q, out_ovf_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [LANES*OUT_W-1:0] skid_data_q, skid_data_d;
  logic [LANES-1:0]       skid_ovf_q, skid_ovf_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   in_fire, out_fire;

  assign in_fire  = in_valid_i & ~skid_valid_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ovf_d    = out_ovf_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ovf_d   = skid_ovf_q;
    cnt_d        = cnt_q;

    if (skid_valid_q) begin
      // No input is accepted while the skid is full; just refill from the skid on drain.
      if (out_fire) begin
        out_data_d   = skid_data_q;
        out_ovf_d    = skid_ovf_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || out_ready_i) begin
      out_valid_d = in_fire;
      if (in_fire) begin
        out_data_d = conv_data;
        out_ovf_d  = conv_ovf;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data;
      skid_ovf_d   = conv_ovf;
    end

    if (out_fire && (|out_ovf_q) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ovf_q   <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ovf_q   <= skid_ovf_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign ovf_count_o = cnt_q;

endmodule
